noc_router_output_arb: RTL

Wormhole output-port arbiter for the NoC router. It sits between the per-input route lookup stages and one router output port. It picks one requesting input by round-robin and holds that grant for the whole worm, from head flit to last flit. Other inputs are blocked until the worm ends.

---
 rtl/noc_router_output_arb.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/noc_router_output_arb.sv
// Wormhole output-port arbiter: round-robin grant held from head to last flit.
// Define NOC_ARB_OUT_REG_EN to insert a 2-entry skid buffer ahead of out_*.
module noc_router_output_arb #(
   parameter int unsigned FLIT_WIDTH = 32,
   parameter int unsigned INPUTS     = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [INPUTS*FLIT_WIDTH-1:0] in_flit,
   input  logic [INPUTS-1:0]            in_last,
   input  logic [INPUTS-1:0]            in_valid,
   output logic [INPUTS-1:0]            in_ready,
   output logic [FLIT_WIDTH-1:0]        out_flit,
   output logic                         out_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [INPUTS-1:0]            grant,
   output logic                         busy
);
   localparam int unsigned IW = $clog2(INPUTS);

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   state_t                r_state, w_state_nxt;
   logic [IW-1:0]         r_ptr, w_ptr_nxt;
   logic [IW-1:0]         r_owner, w_owner_nxt;
   logic [IW-1:0]         w_win, w_sel, w_idx;
   logic                  w_found, w_gnt_en;
   logic [INPUTS-1:0]     w_grant;
   logic [FLIT_WIDTH-1:0] w_mux_flit;
   logic                  w_mux_last, w_mux_valid;
   logic                  w_push_rdy, w_xfer;

   // Round-robin search starting at r_ptr, wrapping past INPUTS-1.
   always_comb begin
      int unsigned k;
      k       = 0;
      w_idx   = '0;
      w_found = 1'b0;
      w_win   = '0;
      for (int unsigned i = 0; i < INPUTS; i++) begin
         k = 32'(r_ptr) + i;
         if (k >= INPUTS) k = k - INPUTS;
         w_idx = IW'(k);
         if (!w_found && in_valid[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   assign w_sel    = (r_state == IDLE) ? w_win : r_owner;
   assign w_gnt_en = (r_state == LOCKED) || w_found;

   always_comb begin
      w_grant    = '0;
      w_mux_flit = '0;
      for (int unsigned i = 0; i < INPUTS; i++) begin
         w_grant[i] = w_gnt_en && (w_sel == IW'(i));
         if (w_grant[i]) w_mux_flit = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
      end
   end

   assign w_mux_last  = |(in_last & w_grant);
   assign w_mux_valid = |(in_valid & w_grant);
   assign w_xfer      = w_mux_valid && w_push_rdy;
   assign in_ready    = w_grant & {INPUTS{w_push_rdy}};
   assign grant       = w_grant;
   assign busy        = (r_state == LOCKED);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_owner <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_owner <= w_owner_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_owner_nxt = r_owner;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_ptr_nxt = (w_win == IW'(INPUTS - 1)) ? '0 : w_win + IW'(1);
               // Lock even if the head stalls so the presented flit stays put.
               if (!(w_xfer && w_mux_last)) begin
                  w_state_nxt = LOCKED;
                  w_owner_nxt = w_win;
               end
            end
         end
         LOCKED: begin
            if (w_xfer && w_mux_last) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

`ifdef NOC_ARB_OUT_REG_EN
   logic [1:0]            r_cnt;
   logic [FLIT_WIDTH-1:0] r_flit0, r_flit1;
   logic                  r_last0, r_last1;
   logic                  w_pop;

   assign w_push_rdy = (r_cnt != 2'd2);
   assign w_pop      = (r_cnt != 2'd0) && out_ready;

   // Entry 0 always holds the oldest flit and feeds out_* directly.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else begin
         case (r_cnt)
            2'd0: begin
               if (w_xfer) begin
                  r_flit0 <= w_mux_flit;
                  r_last0 <= w_mux_last;
                  r_cnt   <= 2'd1;
               end
            end
            2'd1: begin
               if (w_xfer && w_pop) begin
                  r_flit0 <= w_mux_flit;
                  r_last0 <= w_mux_last;
               end else if (w_xfer) begin
                  r_flit1 <= w_mux_flit;
                  r_last1 <= w_mux_last;
                  r_cnt   <= 2'd2;
               end else if (w_pop) begin
                  r_cnt <= 2'd0;
               end
            end
            default: begin
               if (w_pop) begin
                  r_flit0 <= r_flit1;
                  r_last0 <= r_last1;
                  r_cnt   <= 2'd1;
               end
            end
         endcase
      end
   end

   assign out_flit  = r_flit0;
   assign out_last  = r_last0;
   assign out_valid = (r_cnt != 2'd0);
`else
   assign w_push_rdy = out_ready;
   assign out_flit   = w_mux_flit;
   assign out_last   = w_mux_last;
   assign out_valid  = w_mux_valid;
`endif

endmodule
